// File: rtl/pel_pack_pkg.sv
// Shared definitions for the multi-flux pel packing actors.
// Holds the pel width and the round-robin lane arbiter.
package pel_pack_pkg;

  localparam int DATA_WIDTH = 8;
  localparam int MAX_LANES  = 16;
  localparam int LANE_IDX_W = 4;

  typedef struct packed {
    logic                  valid;
    logic [LANE_IDX_W-1:0] lane;
  } grant_t;

  // Searches rr, rr+1, ... wrapping at nLanes; nLanes need not be a power of two.
  function automatic grant_t next_lane(input int unsigned        rr,
                                       input logic [MAX_LANES-1:0] eligible,
                                       input int unsigned        nLanes);
    grant_t      g;
    int unsigned idx;
    g = '0;
    for (int unsigned k = 0; k < MAX_LANES; k++) begin
      idx = rr + k;
      if (idx >= nLanes) begin
        idx = idx - nLanes;
      end
      if ((k < nLanes) && !g.valid && eligible[idx[LANE_IDX_W-1:0]]) begin
        g.valid = 1'b1;
        g.lane  = idx[LANE_IDX_W-1:0];
      end
    end
    return g;
  endfunction

endpackage

// File: rtl/pel_pack_lane.sv
// One flux's partial word: fill count plus the PACK-1 pels already received.
// The completing pel is never stored; it goes straight into the word.
module pel_pack_lane
  import pel_pack_pkg::*;
#(
  parameter int PACK = 4
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       take_i,
  input  logic [DATA_WIDTH-1:0]      pel_i,
  output logic                       done_o,
  output logic [PACK*DATA_WIDTH-1:0] word_o
);

  localparam int CNT_W = $clog2(PACK);

  logic [CNT_W-1:0]                 fill_q, fill_d;
  logic [PACK-2:0][DATA_WIDTH-1:0]  pelBuf_q, pelBuf_d;

  assign done_o = (fill_q == CNT_W'(PACK - 1));
  assign word_o = {pel_i, pelBuf_q};

  always_comb begin
    fill_d   = fill_q;
    pelBuf_d = pelBuf_q;
    if (take_i) begin
      if (done_o) begin
        fill_d = '0;
      end else begin
        for (int k = 0; k < PACK - 1; k++) begin
          if (fill_q == CNT_W'(k)) begin
            pelBuf_d[k] = pel_i;
          end
        end
        fill_d = fill_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      fill_q   <= '0;
      pelBuf_q <= '0;
    end else begin
      fill_q   <= fill_d;
      pelBuf_q <= pelBuf_d;
    end
  end

endmodule

// File: rtl/pel_packer.sv
// Multi-flux pel packer: round-robin reads tagged pels from a FWFT FIFO array
// and writes completed PACK-pel words, tagged with their flux, in the same cycle.
module pel_packer
  import pel_pack_pkg::*;
#(
  parameter int FLUX      = 2,
  parameter int PACK      = 4,
  parameter int TAG_WIDTH = (FLUX > 1) ? $clog2(FLUX) : 1
) (
  input  logic                                       clk_i,
  input  logic                                       rst_ni,
  input  logic [FLUX-1:0][TAG_WIDTH+DATA_WIDTH-1:0]  inPelDout_i,
  input  logic [FLUX-1:0]                            inPelEmpty_i,
  output logic [FLUX-1:0]                            inPelRead_o,
  output logic [TAG_WIDTH+PACK*DATA_WIDTH-1:0]       outWordDin_o,
  input  logic [FLUX-1:0]                            outWordFull_i,
  output logic                                       outWordWrite_o
);

  logic [TAG_WIDTH-1:0]                  rr_q, rr_d;
  logic [FLUX-1:0]                       laneDone;
  logic [FLUX-1:0][PACK*DATA_WIDTH-1:0]  laneWord;
  logic [FLUX-1:0]                       eligible;
  logic [FLUX-1:0][TAG_WIDTH-1:0]        unusedTags;
  grant_t                                grant;

  for (genvar i = 0; i < FLUX; i++) begin : gen_lane
    assign unusedTags[i] = inPelDout_i[i][TAG_WIDTH+DATA_WIDTH-1:DATA_WIDTH];

    pel_pack_lane #(
      .PACK (PACK)
    ) u_lane (
      .clk_i  (clk_i),
      .rst_ni (rst_ni),
      .take_i (inPelRead_o[i]),
      .pel_i  (inPelDout_i[i][DATA_WIDTH-1:0]),
      .done_o (laneDone[i]),
      .word_o (laneWord[i])
    );
  end

  // A lane about to complete a word is only read when its word FIFO has room.
  assign eligible = ~inPelEmpty_i & (~laneDone | ~outWordFull_i);
  assign grant    = next_lane(32'(rr_q), MAX_LANES'(eligible), FLUX);

  always_comb begin
    inPelRead_o    = '0;
    outWordWrite_o = 1'b0;
    outWordDin_o   = '0;
    rr_d           = rr_q;
    if (grant.valid) begin
      for (int i = 0; i < FLUX; i++) begin
        if (grant.lane == LANE_IDX_W'(i)) begin
          inPelRead_o[i] = 1'b1;
          outWordWrite_o = laneDone[i];
          outWordDin_o   = {TAG_WIDTH'(i), laneWord[i]};
        end
      end
      rr_d = (grant.lane == LANE_IDX_W'(FLUX - 1)) ? '0 : TAG_WIDTH'(grant.lane + 1'b1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rr_q <= '0;
    end else begin
      rr_q <= rr_d;
    end
  end

  assert property (@(posedge clk_i) disable iff (!rst_ni) $onehot0(inPelRead_o));
  assert property (@(posedge clk_i) disable iff (!rst_ni) outWordWrite_o |-> (inPelRead_o != '0));

endmodule

// File: tb/tb_pel_packer.sv
// Bench for pel_packer: hand-derived vector table, async reset mid-word,
// randomized FIFO traffic with a per-lane word scoreboard, and FLUX=3 arbitration.
module tb_pel_packer;
  import pel_pack_pkg::*;

  localparam int FLUX  = 2;
  localparam int PACK  = 4;
  localparam int TW    = 1;
  localparam int WW    = TW + PACK * 8;
  localparam int FLUX3 = 3;
  localparam int PACK3 = 2;
  localparam int TW3   = 2;
  localparam int WW3   = TW3 + PACK3 * 8;

  logic clk_i  = 1'b0;
  logic rst_ni = 1'b0;
  always #5 clk_i = ~clk_i;

  logic [FLUX-1:0][TW+7:0]   dout  = '0;
  logic [FLUX-1:0]           empty = '1;
  logic [FLUX-1:0]           full  = '0;
  logic [FLUX-1:0]           rd;
  logic [WW-1:0]             din;
  logic                      wr;

  logic [FLUX3-1:0][TW3+7:0] dout3  = '0;
  logic [FLUX3-1:0]          empty3 = '1;
  logic [FLUX3-1:0]          full3  = '0;
  logic [FLUX3-1:0]          rd3;
  logic [WW3-1:0]            din3;
  logic                      wr3;

  pel_packer #(.FLUX(FLUX), .PACK(PACK)) u_dut (
    .clk_i          (clk_i),
    .rst_ni         (rst_ni),
    .inPelDout_i    (dout),
    .inPelEmpty_i   (empty),
    .inPelRead_o    (rd),
    .outWordDin_o   (din),
    .outWordFull_i  (full),
    .outWordWrite_o (wr)
  );

  pel_packer #(.FLUX(FLUX3), .PACK(PACK3)) u_dut3 (
    .clk_i          (clk_i),
    .rst_ni         (rst_ni),
    .inPelDout_i    (dout3),
    .inPelEmpty_i   (empty3),
    .inPelRead_o    (rd3),
    .outWordDin_o   (din3),
    .outWordFull_i  (full3),
    .outWordWrite_o (wr3)
  );

  int checks = 0;
  int errors = 0;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [1:0]    empty;
    logic [1:0]    full;
    logic [7:0]    pel0;
    logic [7:0]    pel1;
    logic [1:0]    expRead;
    logic          expWrite;
    logic [WW-1:0] expDin;
  } vec_t;

  vec_t vecs[17];

  function automatic vec_t mk(input logic [1:0] e, input logic [1:0] f, input logic [7:0] p0,
                              input logic [7:0] p1, input logic [1:0] r, input logic w,
                              input logic [WW-1:0] d);
    vec_t v;
    v.empty = e; v.full = f; v.pel0 = p0; v.pel1 = p1;
    v.expRead = r; v.expWrite = w; v.expDin = d;
    return v;
  endfunction

  task automatic applyStimulus(input vec_t v);
    @(posedge clk_i);
    #1;
    empty   = v.empty;
    full    = v.full;
    dout[0] = {1'b0, v.pel0};
    dout[1] = {1'b1, v.pel1};
  endtask

  logic [7:0]  inQ[FLUX][$];
  logic [31:0] expQ[FLUX][$];

  task automatic buildTraffic();
    logic [31:0] accum;
    logic [7:0]  p;
    for (int l = 0; l < FLUX; l++) begin
      accum = '0;
      for (int n = 0; n < 6 * PACK; n++) begin
        p = 8'($urandom_range(0, 255));
        inQ[l].push_back(p);
        accum = {p, accum[31:8]};
        if ((n % PACK) == PACK - 1) expQ[l].push_back(accum);
      end
    end
  endtask

  initial begin
    logic [FLUX-1:0]  lastRead;
    logic [2:0]       e3[9];
    logic [2:0]       r3[9];
    logic             w3[9];
    logic [WW3-1:0]   d3[9];
    logic             tag;

    // lane bit 0 = flux 0; expectations derived by hand from rr/cnt per cycle
    vecs[0]  = mk(2'b11, 2'b00, 8'h00, 8'h00, 2'b00, 1'b0, '0);
    vecs[1]  = mk(2'b10, 2'b00, 8'h11, 8'h00, 2'b01, 1'b0, '0);
    vecs[2]  = mk(2'b10, 2'b00, 8'h22, 8'h00, 2'b01, 1'b0, '0);
    vecs[3]  = mk(2'b10, 2'b00, 8'h33, 8'h00, 2'b01, 1'b0, '0);
    vecs[4]  = mk(2'b10, 2'b01, 8'h44, 8'h00, 2'b00, 1'b0, '0);
    vecs[5]  = mk(2'b00, 2'b01, 8'h44, 8'hA0, 2'b10, 1'b0, '0);
    vecs[6]  = mk(2'b00, 2'b00, 8'h44, 8'hA1, 2'b01, 1'b1, 33'h0_44332211);
    vecs[7]  = mk(2'b00, 2'b00, 8'h55, 8'hA1, 2'b10, 1'b0, '0);
    vecs[8]  = mk(2'b01, 2'b00, 8'h55, 8'hA2, 2'b10, 1'b0, '0);
    vecs[9]  = mk(2'b00, 2'b10, 8'h55, 8'hA3, 2'b01, 1'b0, '0);
    vecs[10] = mk(2'b00, 2'b00, 8'h66, 8'hA3, 2'b10, 1'b1, 33'h1_A3A2A1A0);
    vecs[11] = mk(2'b00, 2'b00, 8'h66, 8'hB0, 2'b01, 1'b0, '0);
    vecs[12] = mk(2'b00, 2'b01, 8'h77, 8'hB0, 2'b10, 1'b0, '0);
    vecs[13] = mk(2'b00, 2'b01, 8'h77, 8'hB1, 2'b01, 1'b0, '0);
    vecs[14] = mk(2'b00, 2'b01, 8'h88, 8'hB1, 2'b10, 1'b0, '0);
    vecs[15] = mk(2'b10, 2'b01, 8'h88, 8'h00, 2'b00, 1'b0, '0);
    vecs[16] = mk(2'b10, 2'b00, 8'h88, 8'h00, 2'b01, 1'b1, 33'h0_88776655);

    #2;
    checkOutput("reset read", 64'(rd), 0);
    checkOutput("reset write", 64'(wr), 0);
    checkOutput("reset read flux3", 64'(rd3), 0);
    #20 rst_ni = 1'b1;

    for (int i = 0; i < 17; i++) begin
      applyStimulus(vecs[i]);
      @(negedge clk_i);
      checkOutput($sformatf("vec%0d read", i), 64'(rd), 64'(vecs[i].expRead));
      checkOutput($sformatf("vec%0d write", i), 64'(wr), 64'(vecs[i].expWrite));
      if (vecs[i].expWrite) checkOutput($sformatf("vec%0d din", i), 64'(din), 64'(vecs[i].expDin));
    end

    $display("[TB] async reset with flux 1 mid-word");
    @(posedge clk_i);
    #1;
    empty = 2'b00;
    full  = 2'b00;
    #1 checkOutput("pre-reset grant", 64'(rd), 64'(2'b10));
    #2 rst_ni = 1'b0;
    #1;
    checkOutput("in-reset grant", 64'(rd), 64'(2'b01));
    checkOutput("in-reset write", 64'(wr), 0);
    empty = 2'b11;
    @(negedge clk_i);
    #2 rst_ni = 1'b1;

    $display("[TB] random traffic with scoreboard");
    buildTraffic();
    lastRead = '0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      @(posedge clk_i);
      #1;
      for (int l = 0; l < FLUX; l++) begin
        if (lastRead[l] && inQ[l].size() > 0) void'(inQ[l].pop_front());
      end
      if (inQ[0].size() == 0 && inQ[1].size() == 0) break;
      for (int l = 0; l < FLUX; l++) begin
        empty[l] = (inQ[l].size() == 0);
        dout[l]  = {TW'(l), (inQ[l].size() > 0) ? inQ[l][0] : 8'h00};
        full[l]  = ($urandom_range(0, 3) == 0);
      end
      @(negedge clk_i);
      lastRead = rd;
      checkOutput("read of empty lane", 64'(rd & empty), 0);
      if (wr) begin
        tag = din[WW-1];
        checkOutput("write while full", 64'(full[tag]), 0);
        if (expQ[tag].size() == 0) checkOutput("unexpected word", 64'(din), 0);
        else checkOutput($sformatf("word lane%0d", tag), 64'(din[WW-2:0]), 64'(expQ[tag].pop_front()));
      end
    end
    empty = '1;
    full  = '0;
    checkOutput("pels left lane0", 64'(inQ[0].size()), 0);
    checkOutput("pels left lane1", 64'(inQ[1].size()), 0);
    checkOutput("words left lane0", 64'(expQ[0].size()), 0);
    checkOutput("words left lane1", 64'(expQ[1].size()), 0);

    $display("[TB] three-flux round robin");
    e3 = '{3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 3'b011, 3'b011, 3'b000};
    r3 = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100, 3'b100, 3'b100, 3'b001};
    w3 = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
    d3 = '{'0, '0, '0, {2'd0, 16'h4010}, {2'd1, 16'h5121}, {2'd2, 16'h6232}, '0,
           {2'd2, 16'h8272}, '0};
    for (int c = 0; c < 9; c++) begin
      @(posedge clk_i);
      #1;
      empty3 = e3[c];
      for (int l = 0; l < FLUX3; l++) dout3[l] = {TW3'(l), 8'((c + 1) * 16 + l)};
      @(negedge clk_i);
      checkOutput($sformatf("flux3 c%0d read", c + 1), 64'(rd3), 64'(r3[c]));
      checkOutput($sformatf("flux3 c%0d write", c + 1), 64'(wr3), 64'(w3[c]));
      if (w3[c]) checkOutput($sformatf("flux3 c%0d din", c + 1), 64'(din3), 64'(d3[c]));
    end
    empty3 = '1;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
